mem_stage: RTL and testbench

Memory-access pipeline stage between the EX/MEM register and the register-file write-back. It issues data-memory reads and writes over a request/grant/response handshake, aligns store data and generates byte enables, extracts and extends load data, stalls the pipeline while an access is outstanding, and owns the MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_lsu_align.sv | 62 ++++++
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access-type encodings,
// byte-enable width and the access FSM state type.
package mem_stage_pkg;

    localparam int TYPE_BITS = 3;
    localparam int BE_BITS   = 4;

    localparam logic [TYPE_BITS-1:0] LSU_B  = 3'b000;
    localparam logic [TYPE_BITS-1:0] LSU_H  = 3'b001;
    localparam logic [TYPE_BITS-1:0] LSU_W  = 3'b010;
    localparam logic [TYPE_BITS-1:0] LSU_BU = 3'b100;
    localparam logic [TYPE_BITS-1:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Low two type bits encode the access size: 00 byte, 01 half, 10 word.
    function automatic logic [1:0] lsu_size(input logic [TYPE_BITS-1:0] t);
        return t[1:0];
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational load/store lane logic: misalignment detection, store lane
// replication with byte enables, and load lane extraction with extension.
module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [TYPE_BITS-1:0] i_datatype,
    input  logic [1:0]           i_addr_lo,
    input  logic [31:0]          i_st_data,
    input  logic [31:0]          i_ld_raw,
    output logic                 o_misalign,
    output logic [31:0]          o_st_data,
    output logic [BE_BITS-1:0]   o_be,
    output logic [31:0]          o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_misalign = 1'b0;
        case (i_datatype)
            LSU_W:         o_misalign = |i_addr_lo;
            LSU_H, LSU_HU: o_misalign = i_addr_lo[0];
            default:       o_misalign = 1'b0;
        endcase
    end

    // Store data is replicated across all lanes; the byte enables pick the lane.
    always_comb begin
        o_st_data = i_st_data;
        o_be      = 4'b1111;
        case (lsu_size(i_datatype))
            2'b00: begin
                o_st_data = {4{i_st_data[7:0]}};
                o_be      = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_st_data = {2{i_st_data[15:0]}};
                o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_st_data = i_st_data;
                o_be      = 4'b1111;
            end
        endcase
    end

    assign w_ld_byte = i_ld_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_ld_half = i_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];

    always_comb begin
        o_ld_data = i_ld_raw;
        case (i_datatype)
            LSU_B:   o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            LSU_BU:  o_ld_data = {24'b0, w_ld_byte};
            LSU_H:   o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            LSU_HU:  o_ld_data = {16'b0, w_ld_half};
            default: o_ld_data = i_ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives the data-memory request/grant/response
// handshake, stalls while an access is outstanding and owns MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TYPE_BITS-1:0] ex_datatype,
    input  logic [DATA_W-1:0]    ex_aluout,
    input  logic [DATA_W-1:0]    ex_dm_data,
    input  logic [DATA_W-1:0]    ex_pc2reg,
    input  logic [4:0]           ex_rd_addr,
    input  logic                 ex_reg_wr,
    input  logic                 ex_rd_src,
    input  logic                 ex_dm2reg,
    input  logic                 ex_dm_rd,
    input  logic                 ex_dm_wr,
    input  logic                 hold_i,
    output logic                 dm_req_o,
    output logic                 dm_we_o,
    output logic [ADDR_W-1:0]    dm_addr_o,
    output logic [DATA_W-1:0]    dm_wdata_o,
    output logic [BE_BITS-1:0]   dm_be_o,
    input  logic                 dm_gnt_i,
    input  logic                 dm_rvalid_i,
    input  logic [DATA_W-1:0]    dm_rdata_i,
    output logic                 stall_o,
    output logic                 misalign_o,
    output logic [DATA_W-1:0]    mem_rd_data_o,
    output logic [4:0]           wb_rd_addr_o,
    output logic                 wb_reg_wr_o,
    output logic [DATA_W-1:0]    wb_rd_data_o,
    output mem_state_e           dbg_state_o
);

    // Handshake: dm_req_o is held with stable address/data/enables until the
    // cycle dm_gnt_i is seen; a granted read returns data on a later cycle
    // flagged by dm_rvalid_i. gnt and rvalid never arrive together.

    mem_state_e         r_state;
    mem_state_e         w_state_nxt;
    logic [DATA_W-1:0]  r_buf;
    logic [4:0]         r_wb_rd_addr;
    logic               r_wb_reg_wr;
    logic [DATA_W-1:0]  r_wb_rd_data;

    logic               w_misalign;
    logic [DATA_W-1:0]  w_st_data;
    logic [BE_BITS-1:0] w_be;
    logic [DATA_W-1:0]  w_ld_data;
    logic               w_mem_op;
    logic               w_access;
    logic               w_is_load;
    logic               w_issue;
    logic               w_complete;
    logic [DATA_W-1:0]  w_fwd_data;
    logic [DATA_W-1:0]  w_wb_data;

    mem_lsu_align u_align (
        .i_datatype (ex_datatype),
        .i_addr_lo  (ex_aluout[1:0]),
        .i_st_data  (ex_dm_data),
        .i_ld_raw   (dm_rdata_i),
        .o_misalign (w_misalign),
        .o_st_data  (w_st_data),
        .o_be       (w_be),
        .o_ld_data  (w_ld_data)
    );

    assign w_mem_op  = ex_dm_rd | ex_dm_wr;
    assign w_access  = w_mem_op & ~w_misalign;
    assign w_is_load = ex_dm_rd;
    assign w_issue   = w_access & ((r_state == ST_IDLE) | (r_state == ST_REQ));

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE, ST_REQ: begin
                if (w_access) begin
                    if (dm_gnt_i) begin
                        if (w_is_load) w_state_nxt = ST_RESP;
                        else           w_complete  = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (dm_rvalid_i) w_complete = 1'b1;
            end
            ST_DONE: begin
                if (!hold_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A finished access parks in DONE while frozen so it is not reissued.
        if (w_complete) w_state_nxt = hold_i ? ST_DONE : ST_IDLE;
    end

    assign stall_o    = w_access & (r_state != ST_DONE) & ~w_complete;
    assign dm_req_o   = ~rst & w_issue;
    assign dm_we_o    = dm_req_o & ~w_is_load;
    assign dm_addr_o  = {ex_aluout[ADDR_W-1:2], 2'b00};
    assign dm_wdata_o = w_st_data;
    assign dm_be_o    = (ex_dm_wr & ~ex_dm_rd) ? w_be : '0;
    assign misalign_o = w_mem_op & w_misalign;

    assign w_fwd_data    = ex_rd_src ? ex_pc2reg : ex_aluout;
    assign w_wb_data     = ex_dm2reg ? w_ld_data : w_fwd_data;
    assign mem_rd_data_o = w_fwd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_wb_rd_addr <= '0;
            r_wb_reg_wr  <= 1'b0;
            r_wb_rd_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_complete && hold_i) r_buf <= w_wb_data;
            if (hold_i) begin
                r_wb_reg_wr <= r_wb_reg_wr;
            end else if (stall_o) begin
                r_wb_reg_wr <= 1'b0;
            end else begin
                r_wb_rd_addr <= ex_rd_addr;
                r_wb_reg_wr  <= ex_reg_wr & ~misalign_o;
                r_wb_rd_data <= (r_state == ST_DONE) ? r_buf : w_wb_data;
            end
        end
    end

    assign wb_rd_addr_o = r_wb_rd_addr;
    assign wb_reg_wr_o  = r_wb_reg_wr;
    assign wb_rd_data_o = r_wb_rd_data;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for ALU pass-through,
// stores, loads, hold/DONE behaviour, misalignment and reset mid-access.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ex_datatype = '0;
    logic [31:0] ex_aluout = '0, ex_dm_data = '0, ex_pc2reg = '0;
    logic [4:0]  ex_rd_addr = '0;
    logic        ex_reg_wr = 0, ex_rd_src = 0, ex_dm2reg = 0, ex_dm_rd = 0, ex_dm_wr = 0;
    logic        hold_i = 0, dm_gnt_i = 0, dm_rvalid_i = 0;
    logic [31:0] dm_rdata_i = '0;
    logic        dm_req_o, dm_we_o, stall_o, misalign_o, wb_reg_wr_o;
    logic [31:0] dm_addr_o, dm_wdata_o, mem_rd_data_o, wb_rd_data_o;
    logic [3:0]  dm_be_o;
    logic [4:0]  wb_rd_addr_o;
    mem_state_e  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_datatype(ex_datatype), .ex_aluout(ex_aluout),
        .ex_dm_data(ex_dm_data), .ex_pc2reg(ex_pc2reg), .ex_rd_addr(ex_rd_addr),
        .ex_reg_wr(ex_reg_wr), .ex_rd_src(ex_rd_src), .ex_dm2reg(ex_dm2reg),
        .ex_dm_rd(ex_dm_rd), .ex_dm_wr(ex_dm_wr), .hold_i(hold_i),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
        .dm_wdata_o(dm_wdata_o), .dm_be_o(dm_be_o), .dm_gnt_i(dm_gnt_i),
        .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i), .stall_o(stall_o),
        .misalign_o(misalign_o), .mem_rd_data_o(mem_rd_data_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_reg_wr_o(wb_reg_wr_o),
        .wb_rd_data_o(wb_rd_data_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_dm_rd = 0; ex_dm_wr = 0; ex_dm2reg = 0; ex_reg_wr = 0; ex_rd_src = 0;
        dm_gnt_i = 0; dm_rvalid_i = 0;
    endtask

    // Load with same-cycle grant and read data on the following cycle.
    task automatic do_load(input string tag, input logic [2:0] dt, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        ex_datatype = dt; ex_aluout = addr; ex_rd_addr = rd;
        ex_dm_rd = 1; ex_dm2reg = 1; ex_reg_wr = 1; dm_gnt_i = 1;
        exp_q.push_back(exp);
        #1;
        check({tag, "_req"}, 32'(dm_req_o), 32'd1);
        check({tag, "_stall"}, 32'(stall_o), 32'd1);
        check({tag, "_be"}, 32'(dm_be_o), 32'd0);
        cyc();
        dm_gnt_i = 0;
        check({tag, "_st_resp"}, 32'(dbg_state_o), 32'(ST_RESP));
        check({tag, "_bubble"}, 32'(wb_reg_wr_o), 32'd0);
        dm_rvalid_i = 1; dm_rdata_i = rdata;
        #1;
        check({tag, "_stall_done"}, 32'(stall_o), 32'd0);
        check({tag, "_req_resp"}, 32'(dm_req_o), 32'd0);
        cyc();
        clear_ex();
        check({tag, "_wbdata"}, wb_rd_data_o, exp_q.pop_front());
        check({tag, "_wbwr"}, 32'(wb_reg_wr_o), 32'd1);
        check({tag, "_wbrd"}, 32'(wb_rd_addr_o), 32'(rd));
    endtask

    initial begin
        int req_n;
        int stall_n;

        // Reset with a load presented: request must stay gated.
        ex_datatype = LSU_W; ex_dm_rd = 1;
        cyc(); cyc();
        check("rst_req_gated", 32'(dm_req_o), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
        check("rst_wb_data", wb_rd_data_o, 32'd0);
        check("rst_wb_wr", 32'(wb_reg_wr_o), 32'd0);
        check("rst_wb_rd", 32'(wb_rd_addr_o), 32'd0);
        clear_ex();
        rst = 0;

        // ALU result passes straight through.
        ex_aluout = 32'h1234; ex_reg_wr = 1; ex_rd_addr = 5;
        #1;
        check("alu_stall", 32'(stall_o), 32'd0);
        check("alu_fwd", mem_rd_data_o, 32'h1234);
        cyc();
        check("alu_wbdata", wb_rd_data_o, 32'h1234);
        check("alu_wbrd", 32'(wb_rd_addr_o), 32'd5);
        check("alu_wbwr", 32'(wb_reg_wr_o), 32'd1);

        // PC-derived result selected by rd_src.
        ex_pc2reg = 32'hCAFE0000; ex_rd_src = 1; ex_rd_addr = 6;
        #1;
        check("pc_fwd", mem_rd_data_o, 32'hCAFE0000);
        cyc();
        check("pc_wbdata", wb_rd_data_o, 32'hCAFE0000);
        clear_ex();

        // SB at 0x1003, grant on the third request cycle.
        ex_datatype = LSU_B; ex_aluout = 32'h1003; ex_dm_data = 32'h000000AB; ex_dm_wr = 1;
        req_n = 0; stall_n = 0;
        for (int i = 0; i < 3; i++) begin
            dm_gnt_i = (i == 2);
            #1;
            if (dm_req_o) req_n++;
            if (stall_o) stall_n++;
            if (i == 0) begin
                check("sb_be", 32'(dm_be_o), 32'b1000);
                check("sb_wdata", dm_wdata_o, 32'hABABABAB);
                check("sb_addr", dm_addr_o, 32'h1000);
                check("sb_we", 32'(dm_we_o), 32'd1);
            end
            if (i == 1) check("sb_st_req", 32'(dbg_state_o), 32'(ST_REQ));
            cyc();
        end
        clear_ex();
        check("sb_stall_cycles", 32'(stall_n), 32'd2);
        check("sb_req_cycles", 32'(req_n), 32'd3);
        check("sb_st_idle", 32'(dbg_state_o), 32'(ST_IDLE));

        // SH at 0x1006 with same-cycle grant: no stall.
        ex_datatype = LSU_H; ex_aluout = 32'h1006; ex_dm_data = 32'h12345678;
        ex_dm_wr = 1; dm_gnt_i = 1;
        #1;
        check("sh_wdata", dm_wdata_o, 32'h56785678);
        check("sh_be", 32'(dm_be_o), 32'b1100);
        check("sh_stall", 32'(stall_o), 32'd0);
        check("sh_req", 32'(dm_req_o), 32'd1);
        cyc();
        clear_ex();
        check("sh_st_idle", 32'(dbg_state_o), 32'(ST_IDLE));

        do_load("lb",  LSU_B,  32'h2002, 5'd7,  32'h00800000, 32'hFFFFFF80);
        do_load("lbu", LSU_BU, 32'h2002, 5'd8,  32'h00800000, 32'h00000080);
        do_load("lh",  LSU_H,  32'h2002, 5'd10, 32'h80010000, 32'hFFFF8001);
        do_load("lhu", LSU_HU, 32'h2002, 5'd11, 32'h80010000, 32'h00008001);

        // LW completes while held for 3 cycles: park in DONE, release later.
        ex_datatype = LSU_W; ex_aluout = 32'h4000; ex_rd_addr = 9;
        ex_dm_rd = 1; ex_dm2reg = 1; ex_reg_wr = 1; dm_gnt_i = 1;
        cyc();
        dm_gnt_i = 0; dm_rvalid_i = 1; dm_rdata_i = 32'hDEADBEEF; hold_i = 1;
        #1;
        check("lwh_stall_done", 32'(stall_o), 32'd0);
        cyc();
        dm_rvalid_i = 0; dm_rdata_i = 32'h0;
        req_n = 0;
        for (int i = 0; i < 2; i++) begin
            check("lwh_st_done", 32'(dbg_state_o), 32'(ST_DONE));
            check("lwh_wb_held", wb_rd_data_o, 32'h00008001);
            check("lwh_wbwr_held", 32'(wb_reg_wr_o), 32'd0);
            #1;
            if (dm_req_o) req_n++;
            cyc();
        end
        hold_i = 0;
        #1;
        if (dm_req_o) req_n++;
        check("lwh_release_stall", 32'(stall_o), 32'd0);
        check("lwh_no_reissue", 32'(req_n), 32'd0);
        cyc();
        clear_ex();
        check("lwh_st_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        check("lwh_wbdata", wb_rd_data_o, 32'hDEADBEEF);
        check("lwh_wbwr", 32'(wb_reg_wr_o), 32'd1);
        check("lwh_wbrd", 32'(wb_rd_addr_o), 32'd9);

        // Misaligned LH at 0x3001.
        ex_datatype = LSU_H; ex_aluout = 32'h3001; ex_rd_addr = 3;
        ex_dm_rd = 1; ex_dm2reg = 1; ex_reg_wr = 1;
        #1;
        check("mis_flag", 32'(misalign_o), 32'd1);
        check("mis_req", 32'(dm_req_o), 32'd0);
        check("mis_stall", 32'(stall_o), 32'd0);
        cyc();
        check("mis_wbwr", 32'(wb_reg_wr_o), 32'd0);
        check("mis_st_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        ex_dm_rd = 0; ex_dm_wr = 1; ex_datatype = LSU_W; ex_aluout = 32'h3002;
        #1;
        check("mis_sw_flag", 32'(misalign_o), 32'd1);
        check("mis_sw_req", 32'(dm_req_o), 32'd0);
        ex_dm_wr = 0; ex_dm_rd = 1; ex_datatype = LSU_HU;
        #1;
        check("al_hu_flag", 32'(misalign_o), 32'd0);
        check("al_hu_req", 32'(dm_req_o), 32'd1);
        clear_ex();
        cyc();

        // Reset while waiting for read data; the late rvalid must be ignored.
        ex_datatype = LSU_W; ex_aluout = 32'h5000; ex_rd_addr = 12;
        ex_dm_rd = 1; ex_dm2reg = 1; ex_reg_wr = 1; dm_gnt_i = 1;
        cyc();
        dm_gnt_i = 0;
        check("rr_st_resp", 32'(dbg_state_o), 32'(ST_RESP));
        rst = 1;
        cyc();
        check("rr_st_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        check("rr_wb_data", wb_rd_data_o, 32'd0);
        check("rr_wb_wr", 32'(wb_reg_wr_o), 32'd0);
        check("rr_wb_rd", 32'(wb_rd_addr_o), 32'd0);
        rst = 0;
        clear_ex();
        ex_aluout = 32'h0; ex_rd_addr = 0;
        dm_rvalid_i = 1; dm_rdata_i = 32'h12345678;
        #1;
        check("rr_late_stall", 32'(stall_o), 32'd0);
        check("rr_late_req", 32'(dm_req_o), 32'd0);
        cyc();
        dm_rvalid_i = 0;
        check("rr_late_state", 32'(dbg_state_o), 32'(ST_IDLE));
        check("rr_late_wbwr", 32'(wb_reg_wr_o), 32'd0);
        check("rr_late_wbdata", wb_rd_data_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
